serial_subtractor: RTL and testbench

//  Bit-serial, LSB-first subtractor: computes {bout,diff} = a - b - bin over WIDTH cycles using one

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_sub_cell.sv | 23 ++
 rtl/serial_subtractor.sv | 90 +++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the
// one-bit full-subtractor result.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic d;
    logic bo;
  } sub_bit_t;

endpackage

// File: rtl/serial_sub_cell.sv
// Combinational 1-bit full subtractor: {bo,d} = a - b - bi.
module serial_sub_cell
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  sub_bit_t res;

  always_comb begin
    res.d  = a ^ b ^ bi;
    // Borrow when a=0,b=1, or when the bits match and a borrow ripples in.
    res.bo = (~a & b) | (~(a ^ b) & bi);
  end

  assign d  = res.d;
  assign bo = res.bo;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: {bout,diff} = a - b - bin, one bit per
// cycle through a single full-subtractor cell and a borrow flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             brw;
  logic             d;
  logic             bo;

  serial_sub_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  assign res_nxt   = {d, res_sr[WIDTH-1:1]};
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        ST_CALC: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          brw    <= bo;
          if (cnt == CNT_LAST) begin
            // Publish only on completion so diff/bout hold until the next op ends.
            cnt   <= '0;
            diff  <= res_nxt;
            bout  <= bo;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= ST_CALC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv4 = 0, ir4, ov4, or4 = 0, bin4 = 0, bout4;
  logic [3:0] a4 = 0, b4 = 0, diff4;
  logic       iv8 = 0, ir8, ov8, or8 = 0, bin8 = 0, bout8;
  logic [7:0] a8 = 0, b8 = 0, diff8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .bin(bin4), .out_valid(ov4), .out_ready(or4), .diff(diff4), .bout(bout4));

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .bin(bin8), .out_valid(ov8), .out_ready(or8), .diff(diff8), .bout(bout8));

  int checks = 0;
  int errors = 0;
  logic [4:0] q4[$];
  logic [8:0] q8[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] gold4(input logic [3:0] x, input logic [3:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return 5'(r);
  endfunction

  function automatic logic [8:0] gold8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return 9'(r);
  endfunction

  // Result monitors: a handshake is seen at the negedge before the consuming edge.
  always @(negedge clk) begin
    if (rst_n && ov4 && or4) begin
      chk("w4_result_expected", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) chk("w4_result", {27'd0, bout4, diff4}, {27'd0, q4.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      chk("w8_result_expected", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) chk("w8_result", {23'd0, bout8, diff8}, {23'd0, q8.pop_front()});
    end
  end

  // Presents an op to the 4-bit DUT and returns at accept edge + #1.
  task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic c, input bit push);
    int n;
    @(posedge clk); #1;
    iv4 = 1; a4 = x; b4 = y; bin4 = c;
    n = 0;
    forever begin
      @(negedge clk);
      if (ir4) break;
      n++;
      if (n >= 100) break;
    end
    chk("w4_accept_timeout", 32'(n < 100), 32'd1);
    if (push) q4.push_back(gold4(x, y, c));
    @(posedge clk); #1;
    iv4 = 0;
  endtask

  task automatic wait_out4();
    int n;
    n = 0;
    while (!ov4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w4_done_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 500), 32'd1);
  endtask

  initial begin
    int sent4, sent8, cyc;
    bit acc4, acc8;

    // Reset state
    #23;
    chk("rst_in_ready4", 32'(ir4), 32'd1);
    chk("rst_out_valid4", 32'(ov4), 32'd0);
    chk("rst_diff4", {27'd0, bout4, diff4}, 32'd0);
    chk("rst_in_ready8", 32'(ir8), 32'd1);
    chk("rst_res8", {23'd0, bout8, diff8}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // 1: 5-3-0, latency exactly WIDTH cycles
    or4 = 1;
    send4(4'd5, 4'd3, 1'b0, 1);
    chk("t1_in_ready_busy", 32'(ir4), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("t1_not_yet_valid", 32'(ov4), 32'd0);
    @(posedge clk);
    #1 chk("t1_valid_at_4", 32'(ov4), 32'd1);
    chk("t1_diff", {27'd0, bout4, diff4}, 32'h02);

    // 2: borrow cases
    send4(4'd0, 4'd1, 1'b0, 1);
    send4(4'hF, 4'hF, 1'b1, 1);
    send4(4'd8, 4'd0, 1'b1, 1);
    drain();

    // 3: backpressure with a competing in_valid
    or4 = 0;
    send4(4'd7, 4'd2, 1'b0, 1);
    wait_out4();
    @(posedge clk); #1;
    iv4 = 1; a4 = 4'hB; b4 = 4'h3; bin4 = 1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", 32'(ov4), 32'd1);
      chk("t3_hold_ready", 32'(ir4), 32'd0);
      chk("t3_hold_diff", {27'd0, bout4, diff4}, 32'h05);
    end
    or4 = 1;
    @(posedge clk); #1;
    chk("t3_release_idle", {30'd0, ir4, ov4}, 32'b10);
    q4.push_back(gold4(4'hB, 4'h3, 1'b1));
    @(posedge clk); #1;
    chk("t3_accept_next", 32'(ir4), 32'd0);
    iv4 = 0;
    wait_out4();
    drain();

    // 4: operands churn during CALC
    send4(4'd6, 4'd9, 1'b1, 1);
    repeat (4) begin
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      @(posedge clk); #1;
    end
    drain();

    // 5: reset mid-CALC at cnt=2
    send4(4'd12, 4'd1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("t5_rst_ready", 32'(ir4), 32'd1);
    chk("t5_rst_valid", 32'(ov4), 32'd0);
    chk("t5_rst_res", {27'd0, bout4, diff4}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    send4(4'd9, 4'd4, 1'b0, 1);
    drain();

    // 6: random back-to-back ops on both widths with random stalls
    sent4 = 0; sent8 = 0; acc4 = 0; acc8 = 0; cyc = 0;
    while ((sent4 < 200 || sent8 < 200 || q4.size() != 0 || q8.size() != 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      or4 = ($urandom_range(0, 3) != 0);
      or8 = ($urandom_range(0, 3) != 0);
      if (acc4) begin iv4 = 0; acc4 = 0; end
      if (acc8) begin iv8 = 0; acc8 = 0; end
      if (!iv4 && sent4 < 200) begin
        iv4 = 1; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      end
      if (!iv8 && sent8 < 200) begin
        iv8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      @(negedge clk);
      if (iv4 && ir4) begin q4.push_back(gold4(a4, b4, bin4)); sent4++; acc4 = 1; end
      if (iv8 && ir8) begin q8.push_back(gold8(a8, b8, bin8)); sent8++; acc8 = 1; end
    end
    chk("t6_timeout", 32'(cyc < 20000), 32'd1);
    chk("t6_sent4", 32'(sent4), 32'd200);
    chk("t6_sent8", 32'(sent8), 32'd200);
    iv4 = 0; iv8 = 0;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
